// File: rtl/stark_const_packer.sv
// stark_const_packer: packs instructions upward and shared constants downward into 512-bit lines
module stark_const_packer #(
  parameter int          POS_LSB  = 17,
  parameter int          ISZ_LSB  = 25,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_ins,
  input  logic [1:0]   in_nc,
  input  logic [31:0]  in_c1,
  input  logic [31:0]  in_c2,
  input  logic         in_last,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_line,
  output logic [4:0]   out_ninsn,
  output logic [4:0]   out_ncnst
);
  typedef enum logic {FILL, EMIT} st_t;
  st_t         st_q, st_d;
  logic [31:0] buf_q [16];
  logic [31:0] buf_d [16];
  logic [4:0]  ip_q, ip_d, cp_q, cp_d, free, need, occ;
  logic        has1, has2, hit1, hit2, new1, new2, same, fits, acc, close;
  logic [3:0]  idx1, idx2, w1, w2, p1, p2;
  logic [1:0]  n_new;
  logic [31:0] ins_p;
  // constant lookup against the occupied top of the buffer, slot allocation and field patching
  always_comb begin
    has1 = in_nc != 2'd0;
    has2 = in_nc[1];
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx1 = 4'd0;
    idx2 = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (5'(k) >= 5'd16 - cp_q && buf_q[k] == in_c1) begin
        hit1 = 1'b1;
        idx1 = 4'(k);
      end
      if (5'(k) >= 5'd16 - cp_q && buf_q[k] == in_c2) begin
        hit2 = 1'b1;
        idx2 = 4'(k);
      end
    end
    new1  = has1 & !hit1;
    same  = new1 & (in_c2 == in_c1);
    new2  = has2 & !hit2 & !same;
    w1    = 4'(5'd15 - cp_q);
    w2    = w1 - {3'b0, new1};
    p1    = !has1 ? 4'h0 : hit1 ? idx1 : w1;
    p2    = !has2 ? 4'h0 : hit2 ? idx2 : same ? w1 : w2;
    n_new = {1'b0, new1} + {1'b0, new2};
    free  = 5'd16 - ip_q - cp_q;
    need  = 5'd1 + {3'b0, n_new};
    occ   = ip_q + cp_q;
    fits  = need <= free;
    ins_p = in_ins;
    ins_p[POS_LSB +: 8] = {p2, p1};
    ins_p[ISZ_LSB +: 4] = {1'b0, has2, 1'b0, has1};
    in_ready = (st_q == FILL) & !rst & (!in_valid | fits);
    acc   = (st_q == FILL) & in_valid & fits;
    close = (in_valid & !fits) | (acc & in_last) | (flush & (occ != 5'd0 | acc)) | (acc & (occ + need == 5'd16));
  end
  // next state: write accepted words while filling, clear the buffer once the line is taken
  always_comb begin
    st_d = st_q;
    ip_d = ip_q;
    cp_d = cp_q;
    buf_d = buf_q;
    if (st_q == EMIT) begin
      if (out_ready) begin
        st_d = FILL;
        ip_d = 5'd0;
        cp_d = 5'd0;
        buf_d = '{default: NOP_WORD};
      end
    end else begin
      if (acc) begin
        buf_d[ip_q[3:0]] = ins_p;
        if (new1) buf_d[w1] = in_c1;
        if (new2) buf_d[w2] = in_c2;
        ip_d = ip_q + 5'd1;
        cp_d = cp_q + {3'b0, n_new};
      end
      st_d = close ? EMIT : FILL;
    end
  end
  // state and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= FILL;
      ip_q  <= 5'd0;
      cp_q  <= 5'd0;
      buf_q <= '{default: NOP_WORD};
    end else begin
      st_q  <= st_d;
      ip_q  <= ip_d;
      cp_q  <= cp_d;
      buf_q <= buf_d;
    end
  end
  assign out_valid = st_q == EMIT;
  assign out_ninsn = ip_q;
  assign out_ncnst = cp_q;
  for (genvar w = 0; w < 16; w++) begin : g_o
    assign out_line[32*w +: 32] = buf_q[w];
  end
endmodule

// File: tb/tb_stark_const_packer.sv
// tb_stark_const_packer: randomized scoreboard bench against a list-based line model
module tb_stark_const_packer;
  localparam logic [31:0] NOP = 32'h0000_0000;
  logic         clk = 0, rst = 1, in_valid = 0, in_ready, in_last = 0, flush = 0;
  logic         out_valid, out_ready;
  logic [31:0]  in_ins = 0, in_c1 = 0, in_c2 = 0;
  logic [1:0]   in_nc = 0;
  logic [511:0] out_line;
  logic [4:0]   out_ninsn, out_ncnst;
  int vec = 0, errs = 0;
  logic bp = 0, rnd = 0;
  typedef struct {logic [511:0] l; int ni; int nc;} exp_t;
  exp_t sb[$];
  logic [31:0] mi[$], mc[$];
  logic memit = 0;

  stark_const_packer dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .in_nc(in_nc), .in_c1(in_c1), .in_c2(in_c2), .in_last(in_last), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_line(out_line), .out_ninsn(out_ninsn), .out_ncnst(out_ncnst));

  always #5 clk = ~clk;

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk);
      #2 out_ready = bp ? 1'b0 : rnd ? ($urandom % 4 != 0) : 1'b1;
    end
  end

  task automatic chk(input string n, input logic [511:0] a, input logic [511:0] e);
    vec++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  function automatic int idx(input logic [31:0] q[$], input logic [31:0] v);
    foreach (q[j]) if (q[j] == v) return j;
    return -1;
  endfunction

  // monitor and reference model, evaluated mid-cycle on the inputs the next edge will see
  always @(negedge clk) begin : m
    int n, need, occ0, p1, p2;
    logic fits, acc, cl;
    logic [31:0] v;
    logic [511:0] l;
    logic [31:0] t[$];
    if (rst) begin
      chk("in_ready_rst", in_ready, 0);
      sb.delete(); mi.delete(); mc.delete();
      memit = 0;
    end else begin
      chk("out_valid", out_valid, memit);
      if (out_valid) begin
        if (sb.size() == 0) chk("unexpected_line", 1, 0);
        else begin
          chk("out_line", out_line, sb[0].l);
          chk("out_ninsn", out_ninsn, sb[0].ni);
          chk("out_ncnst", out_ncnst, sb[0].nc);
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (memit) begin
        chk("in_ready_emit", in_ready, 0);
        if (out_ready) begin
          memit = 0; mi.delete(); mc.delete();
        end
      end else begin
        n = (in_nc == 2'd3) ? 2 : int'(in_nc);
        t = mc;
        if (n >= 1 && idx(t, in_c1) < 0) t.push_back(in_c1);
        if (n == 2 && idx(t, in_c2) < 0) t.push_back(in_c2);
        need = 1 + t.size() - mc.size();
        occ0 = mi.size() + mc.size();
        fits = need <= 16 - occ0;
        chk("in_ready", in_ready, !in_valid || fits);
        acc = in_valid && fits;
        if (acc) begin
          mc = t;
          p1 = n >= 1 ? 15 - idx(mc, in_c1) : 0;
          p2 = n == 2 ? 15 - idx(mc, in_c2) : 0;
          v = in_ins;
          v[24:17] = {4'(p2), 4'(p1)};
          v[28:25] = {2'(n == 2 ? 1 : 0), 2'(n >= 1 ? 1 : 0)};
          mi.push_back(v);
        end
        cl = (in_valid && !fits) || (acc && in_last) || (flush && (occ0 > 0 || acc)) || (acc && mi.size() + mc.size() == 16);
        if (cl) begin
          l = {16{NOP}};
          foreach (mi[i]) l[32*i +: 32] = mi[i];
          foreach (mc[j]) l[32*(15-j) +: 32] = mc[j];
          sb.push_back('{l, mi.size(), mc.size()});
          memit = 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] ins, input logic [1:0] nc, input logic [31:0] a, input logic [31:0] b,
                      input logic last, input logic fl);
    int t = 0;
    in_valid = 1; in_ins = ins; in_nc = nc; in_c1 = a; in_c2 = b; in_last = last; flush = fl;
    @(negedge clk);
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      errs++;
      $display("FAIL send_timeout: in_ready stuck at 0, want 1 within 60 cycles");
    end
    @(posedge clk);
    #1 in_valid = 0; in_last = 0; flush = 0;
  endtask

  task automatic do_flush();
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
  endtask

  task automatic wait_ov();
    int t = 0;
    while (!out_valid && t < 40) begin
      @(posedge clk);
      #1 t++;
    end
    chk("wait_out_valid", out_valid, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_line", out_line, {16{NOP}});
    chk("rst_ninsn", out_ninsn, 0);
    chk("rst_ncnst", out_ncnst, 0);
    @(posedge clk);
    #1;
    send(32'hA000_0001, 1, 32'h1234_5678, 0, 1, 0);
    repeat (3) send($urandom, 1, 32'hDEAD_BEEF, 0, 0, 0);
    do_flush();
    send(32'h0FFF_FFFF, 2, 5, 5, 1, 0);
    for (int i = 0; i < 7; i++) send($urandom, 1, 32'h100 + i, 0, 0, 0);
    send(32'hB000_0008, 2, 32'h200, 32'h201, 1, 0);
    repeat (3) @(posedge clk);
    #1 bp = 1;
    send(32'hC000_0000, 2, 32'h77, 32'h88, 1, 0);
    wait_ov();
    repeat (5) @(posedge clk);
    #1 bp = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) send($urandom, 0, $urandom, $urandom, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    do_flush();
    repeat (3) @(posedge clk);
    #1 bp = 1;
    send(32'hD000_0000, 1, 32'h99, 0, 1, 0);
    wait_ov();
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    bp = 0;
    @(negedge clk);
    chk("rst_emit_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rnd = 1;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom % 3 == 0) ? $urandom : 32'($urandom_range(0, 5));
      b = ($urandom % 3 == 0) ? $urandom : 32'($urandom_range(0, 5));
      send($urandom, 2'($urandom), a, b, $urandom % 8 == 0, $urandom % 10 == 0);
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd = 0;
    do_flush();
    for (int t = 0; t < 100 && (sb.size() != 0 || out_valid); t++) @(posedge clk);
    #1 chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/stark_const_packer.md
# stark_const_packer

Instruction-line builder for the Stark front end that produces the cache-line format consumed by the constant decoder. It accepts a stream of 32-bit instructions, each carrying zero, one or two 32-bit extended constants, and packs them into 512-bit lines. Instructions fill the line from word 0 upward and constants fill it from word 15 downward. Each instruction's constant-position and size fields are patched in, and identical constants within a line are shared. Closed lines are emitted over a valid/ready handshake toward the I-cache fill path or the loader.

## Interface
Parameters:
- POS_LSB, 17: LSB of the 8-bit pos field in the instruction word. pos[3:0] locates constant 1 and pos[7:4] locates constant 2.
- ISZ_LSB, 25: LSB of the 4-bit isz field in the instruction word. isz[1:0] is for constant 1 and isz[3:2] is for constant 2.
- NOP_WORD, 32'h0000_0000: filler word for unused middle slots.

Ports:
- clk  in  1  clock; the block uses this single clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  instruction accepted this cycle when in_valid & in_ready.
- in_ins  in  32  instruction; its pos and isz fields are overwritten by the block.
- in_nc  in  2  number of constants: 0, 1 or 2. The value 3 is treated as 2.
- in_c1  in  32  constant 1.
- in_c2  in  32  constant 2.
- in_last  in  1  close the line after this instruction.
- flush  in  1  close the current line if it is non-empty.
- out_valid  out  1  line available.
- out_ready  in  1  consumer takes the line.
- out_line  out  512  packed line; word w occupies bits [32w+31:32w].
- out_ninsn  out  5  instruction count in the line, 0–16.
- out_ncnst  out  5  constant word count in the line, 0–16.

## Operation
- State: 16-word buffer, instruction pointer ip (0–16), constant count cp (0–16), FSM {FILL, EMIT}.
- Free words: free = 16 − ip − cp.
- Dedup for c1: compare against the occupied constant words 16−cp..15.
- Dedup for c2: compare against the occupied constant words, and against c1 when c1 is new.
- Equal c1 and c2 share a single word.
- Space needed: need = 1 + (number of new constant words).
- Constant slots are allocated at word 15−cp, then 14−cp. Constant 1 is allocated before constant 2.
- Field patch:
  - pos nibble = word index of the constant.
  - isz code = 2'b01 when the constant is present, 2'b00 when absent.
  - The pos nibble for an absent constant = 4'h0.
- In FILL, the instruction is accepted when in_valid & need ≤ free. On acceptance:
  - the patched instruction is written to word ip and ip increments;
  - new constants are written and cp increments by the number of new words.
- Transition FILL→EMIT on any of the following:
  - in_valid & need > free, with the instruction not accepted;
  - in_last accepted;
  - flush with ip + cp > 0, or with an instruction accepted in the same cycle;
  - ip + cp = 16 after acceptance.
- EMIT behaviour:
  - out_valid = 1.
  - out_line contains words 0..ip−1 = instructions, words ip..15−cp = NOP_WORD, words 16−cp..15 = constants.
  - The line is held stable until out_ready.
  - On out_valid & out_ready: buffer cleared, ip = cp = 0, return to FILL.
- flush with an empty buffer and no acceptance: no emit, stay in FILL.
- in_ready = (state == FILL) & !rst & (!in_valid | need ≤ free). in_ready is low throughout EMIT.
- A rejected instruction (need > free) is retained by the source and accepted into the fresh line after the emit completes.

## Timing
- Reset (rst high at a clk edge):
  - state = FILL, ip = cp = 0, buffer = NOP_WORD;
  - out_valid = 0, out_line = {16{NOP_WORD}}, out_ninsn = out_ncnst = 0;
  - in_ready = 0 while rst is asserted.
- Reset mid-EMIT discards the line with no handshake.
- Acceptance-to-emit latency:
  - out_valid rises in the cycle after the closing condition's edge;
  - the minimum line turnaround is FILL accept, EMIT, FILL: 1 cycle of EMIT with out_ready already high.
- The back-to-back maximum rate is one instruction per cycle within a line, plus one EMIT cycle per line.
- in_ready depends combinationally on in_valid, in_nc, in_c1 and in_c2. in_ready is independent of out_ready.
- out_* are registered; no combinational path exists from out_ready to out_valid.

## Test plan
- **Single instruction:** nc=1, c1=32'h1234_5678, in_last=1. Required line:
  - word0 = ins with pos=8'h0F, isz=4'b0001;
  - word15 = 32'h1234_5678;
  - words 1–14 = NOP_WORD;
  - out_ninsn = 1, out_ncnst = 1.
- **Dedup:** 3 instructions each with c1=32'hDEAD_BEEF, then flush.
  - Required: one constant word at word 15, all three instructions with pos[3:0] = 4'hF, out_ncnst = 1.
- **Shared pair:** nc=2 with c1=c2=5.
  - Required: one word at word 15, pos = 8'hFF, isz = 4'b0101.
- **Overflow:** 7 instructions with nc=1 and distinct constants, so ip=7, cp=7, free=2. The 8th instruction has nc=2 with new constants, so need=3.
  - Required: in_ready = 0 for the 8th instruction and the line emitted with 7 and 7.
  - Required: the 8th instruction then lands at word 0 of the next line, with constants at words 15 and 14 and pos = 8'hEF.
- **Backpressure:** out_ready held low 5 cycles during EMIT.
  - Required: out_line stable, in_ready = 0; the line is accepted on the first out_ready cycle.
- **Edge cases:**
  - 16 instructions with nc=0 fill the line and emit automatically with out_ninsn = 16.
  - flush on an empty buffer produces no out_valid.
  - rst during EMIT gives out_valid = 0 on the next cycle.
